// File: rtl/bk_ps2_pkg.sv
// Shared PS/2 receiver definitions: receiver FSM encoding, frame layout constants,
// default line timings and the frame validity check.
package bk_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS  = 11;
    // start, parity and stop bracket the payload
    localparam int unsigned PS2_DATA_BITS   = PS2_FRAME_BITS - 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 2500;
    localparam int unsigned DEF_FILTER_LEN  = 4;

    // Good frame: stop bit high and odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [PS2_DATA_BITS-1:0] data,
                                      input logic parity, input logic stop);
        return stop & (^{data, parity});
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers. Reports pushes lost to a full
// FIFO (ovf_set) and pops that drain the last entry (drain).
module ps2_sync_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
) (
    input  logic          clk25,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          ovf_set,
    output logic          drain
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   rd_ptr_inc;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rd_ptr_inc = rd_ptr_q + 1'b1;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~do_pop;
    assign drain   = do_pop & ~do_push & (wr_ptr_q == rd_ptr_inc);

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line sync, clock deglitch, frame FSM with timeout and a
// scancode FIFO. Define PS2_RX_ERRCNT_EN to build the saturating frame error counter.
module ps2_rx_fifo
    import bk_ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       rd_i,
    output logic [7:0] data_o,
    output logic       avail_o,
    output logic       overflow_o,
    output logic       frame_err_o,
    output logic [7:0] err_count_o
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

    logic [1:0]               clk_sync_q, data_sync_q;
    logic                     filt_q;
    logic [FLT_W-1:0]         flt_cnt_q;
    logic                     flt_flip, sample, sample_bit;

    ps2_state_e               state_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic                     parity_q;
    logic [TO_W-1:0]          to_cnt_q;
    logic                     frame_err_q;
    logic                     push;

    logic                     fifo_empty, fifo_full_unused, ovf_set, drain;
    logic                     overflow_q;

    // Lines idle high, so the synchronisers reset to 1 as well.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign flt_flip   = (clk_sync_q[1] != filt_q) && (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
    assign sample     = flt_flip & filt_q;
    assign sample_bit = data_sync_q[1];

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_sync_q[1] == filt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_flip) begin
            filt_q    <= ~filt_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    assign push = sample && (state_q == STOP) && frame_ok(shift_q, parity_q, sample_bit);

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (sample) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!sample_bit) begin
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q   <= {sample_bit, shift_q[PS2_DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(PS2_DATA_BITS - 1)) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= sample_bit;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        frame_err_q <= ~frame_ok(shift_q, parity_q, sample_bit);
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                // Stalled frame: drop the partial byte and resync on the next start bit.
                if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    frame_err_q <= 1'b1;
                    state_q     <= IDLE;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    ps2_sync_fifo #(
        .AW(FIFO_AW),
        .DW(PS2_DATA_BITS)
    ) u_fifo (
        .clk25  (clk25),
        .reset_n(reset_n),
        .push   (push),
        .wdata  (shift_q),
        .pop    (rd_i),
        .rdata  (data_o),
        .full   (fifo_full_unused),
        .empty  (fifo_empty),
        .ovf_set(ovf_set),
        .drain  (drain)
    );

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end else if (drain) begin
            overflow_q <= 1'b0;
        end
    end

    assign avail_o     = ~fifo_empty;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;

`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (frame_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = 8'h00;
`endif

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver on the keyboard path.
- Synchronises and deglitches PS2_Clk/PS2_Data, deserialises 11-bit frames and checks start, odd parity and stop bits.
- Queues good scancodes in a small FIFO that the keyboard decoder drains.
- Sits directly upstream of the scancode-to-ASCII stage that drives ascii/kbd_available into the core. Runs in the clk25 domain.

Parameters:
- FILTER_LEN, 4: consecutive identical samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYC, 2500: clk25 cycles allowed between falling edges inside a frame (100 us).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8.

Ports:
- clk25  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk_i  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_i  in  1  raw PS/2 data line, asynchronous.
- rd_i  in  1  pop strobe; one byte per cycle while high.
- data_o  out  8  FIFO head byte; valid only while avail_o=1.
- avail_o  out  1  FIFO not empty.
- overflow_o  out  1  sticky; a good byte was dropped because the FIFO was full.
- frame_err_o  out  1  one-cycle pulse on parity, start, stop or timeout error.
- err_count_o  out  8  saturating error count (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk25). Reset is asynchronous, active-low (reset_n). Every flop resets asynchronously.
- Reset values: data_o=0, avail_o=0, overflow_o=0, frame_err_o=0, err_count_o=0, FSM=IDLE, FIFO empty, filtered clock=1.
- Input conditioning:
  - Both lines pass through 2-FF synchronisers.
  - Filtered clock toggles only after FILTER_LEN consecutive synchronised samples differ from its current level.
  - A sample point is a 1->0 transition of the filtered clock. Data is sampled from the synchronised line in that same cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on a sample with data=0 (start), clear the bit counter and go to DATA. A start sample with data=1 raises frame_err_o and stays in IDLE.
  - DATA: shift each sample into bit position 7 of the shift register (LSB arrives first). After the 8th sample go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: valid when stop=1 and the XOR of 8 data bits plus parity = 1. Valid -> push byte. Invalid -> frame_err_o pulse, no push. Always return to IDLE.
- Timeout:
  - Counter clears on every sample and counts while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYC -> frame_err_o pulse, FSM to IDLE, partial byte discarded.
  - Counter width is clog2(TIMEOUT_CYC+1).
- Latency: a pushed byte appears on data_o with avail_o=1 on the cycle after the STOP sample (first-word fall-through).
- FIFO rules:
  - rd_i with avail_o=0 is ignored. It does not underflow and does not move the pointers.
  - Push while full and no pop -> byte dropped, overflow_o set. overflow_o clears only on reset or on a pop that leaves the FIFO empty.
  - Push and pop in the same cycle while full -> both happen; no overflow.
  - Push and pop in the same cycle while empty -> push only (head not yet valid).
  - Pointers are FIFO_AW+1 bits with wrap bit; full = addresses equal and wrap bits differ.
- frame_err_o is never asserted on the same cycle as a push. At most one pulse per frame.

Optional Feature:
- Macro PS2_RX_ERRCNT_EN.
- Defined: err_count_o increments on every frame_err_o pulse and saturates at 8'hFF. It is cleared only by reset.
- Undefined: no counter logic is built and err_count_o is tied to 8'h00.

Decomposition:
- Shared package bk_ps2_pkg holds:
  - FSM state encoding: IDLE=0, DATA=1, PARITY=2, STOP=3, 2 bits.
  - Frame constants: PS2_DATA_BITS=8, PS2_FRAME_BITS=11.
  - Default TIMEOUT_CYC and FILTER_LEN.
- One sub-module: ps2_sync_fifo, a parameterised FWFT FIFO with push, pop, full, empty and an overflow-set output. The receiver FSM, filter and timeout stay in the top module.

Test Plan:
- Frame for 0x1C, correct odd parity=0 (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> data_o=8'h1C, avail_o=1 one cycle after the stop sample; frame_err_o never asserted.
- Same frame with parity=1 -> no push, avail_o stays 0, frame_err_o one-cycle pulse; with PS2_RX_ERRCNT_EN err_count_o=1.
- Send 9 good frames 0x01..0x09 with rd_i=0 -> 8 entries held, overflow_o=1. Popping 8 times returns 0x01..0x08 in order; overflow_o clears on the 8th pop.
- Drive 5 clock edges then stop the PS/2 clock -> frame_err_o after TIMEOUT_CYC cycles, FSM back to IDLE. A following full frame 0xF0 is received correctly.
- Inject 2-cycle low glitches on ps2_clk_i (shorter than FILTER_LEN) during a 0x5A frame -> byte received as 0x5A, no error.
- Assert reset_n=0 mid-frame (after 4 data bits) -> all outputs return to reset values immediately (asynchronously). A fresh frame 0x29 after release is received intact.
